nfc_rx_ctrl: RTL and testbench
==============================

Name: nfc_rx_ctrl

Overview:
- Far-end consumer of 16-bit native flow control (NFC) messages on the Aurora link.
- Decodes each message as XOFF, XON, timed pause or illegal, and gates the local user TX AXI-Stream path to match.
- The gate is inserted between the user data source and the Aurora TX user interface.
- Honors frame boundaries so a pause never splits a frame, and bounds XOFF with an optional watchdog.

Parameters:
DATA_W, 32, width of the gated AXI-Stream data bus
QUANTUM, 8, clock cycles per unit of timed-pause count
GATE_ON_LAST, 1, 1 = pause takes effect only between frames; 0 = pause at the next beat boundary
XOFF_TIMEOUT, 65535, cycles in XOFF before auto-resume; 0 disables the watchdog

Ports:
clk  input  1  clock; all logic is in this single domain
rst_n  input  1  asynchronous reset, active low
nfc_valid  input  1  NFC message valid
nfc_data  input  16  NFC message: [8] = XOFF flag, [7:0] = pause count, [15:9] must be 0
nfc_ready  output  1  NFC message accept
s_axis_tvalid  input  1  upstream beat valid
s_axis_tready  output  1  upstream beat accept
s_axis_tdata  input  DATA_W  upstream data
s_axis_tlast  input  1  upstream end of frame
m_axis_tvalid  output  1  downstream beat valid
m_axis_tready  input  1  downstream ready (Aurora TX)
m_axis_tdata  output  DATA_W  downstream data
m_axis_tlast  output  1  downstream end of frame
paused  output  1  high while the gate is closed
nfc_err  output  1  one-cycle pulse on an illegal message
xoff_timeout  output  1  one-cycle pulse on watchdog auto-resume

Behaviour:
Reset values:
- State = RUN.
- gate_open = 0 for the first cycle after release, then 1.
- nfc_ready = 0.
- paused = 1 while in reset; nfc_err = 0; xoff_timeout = 0.
- in_frame = 0; all counters = 0.

Data path (combinational):
- m_axis_tvalid = s_axis_tvalid & gate_open.
- s_axis_tready = m_axis_tready & gate_open.
- tdata and tlast pass straight through.
- No buffering, zero latency.
- gate_open is a register equal to (state == RUN), delayed one cycle.
- paused = ~gate_open.

NFC interface:
- nfc_ready is 1 every cycle after reset release; a message is taken whenever nfc_valid = 1.

Message decode:
- nfc_data[15:9] != 0: illegal. Pulse nfc_err, drop the message, state unchanged.
- [8] = 1: XOFF. The count field is ignored.
- [8] = 0 and [7:0] = 0: XON.
- [8] = 0 and [7:0] = N != 0: timed pause of N*QUANTUM cycles.

Frame tracking:
- in_frame is set on an accepted beat with tlast = 0.
- in_frame is cleared on an accepted beat with tlast = 1.

States and transitions:
RUN:
- XOFF or timed pause received: go to DRAIN if GATE_ON_LAST = 1 and in_frame = 1 (and the cycle does not accept the final tlast beat); otherwise go directly to the pending pause state.
- The request is recorded as pend_type and pend_cnt.
DRAIN:
- Gate stays open; waits for the beat with tlast to be accepted.
- On that beat: XOFF goes to PAUSE_XOFF; timed pause loads the counter with N*QUANTUM-1 and goes to PAUSE_TIMED.
- A newer XOFF or timed message overwrites the pending request.
- XON cancels the pause and returns to RUN.
PAUSE_XOFF:
- The watchdog counts up.
- XON returns to RUN.
- A timed message loads the counter and goes to PAUSE_TIMED.
- XOFF clears the watchdog.
- Watchdog reaching XOFF_TIMEOUT-1 (when nonzero) returns to RUN and pulses xoff_timeout.
PAUSE_TIMED:
- The counter decrements; at 0 the block returns to RUN.
- XON returns to RUN immediately.
- XOFF goes to PAUSE_XOFF with the watchdog cleared.
- A new timed message reloads the counter (no accumulation).

Latency:
- A message accepted at edge T, when no drain is needed, closes the gate from cycle T+2 (state at T+1, gate_open register at T+2).
- A beat may be accepted in cycle T+1; this is legal because it is at a beat boundary.
- Timed pause: paused is high for exactly N*QUANTUM cycles.

Widths:
- The timed counter is 8+clog2(QUANTUM) bits.
- The watchdog is clog2(XOFF_TIMEOUT+1) bits.
- Neither counter ever wraps.

Boundary cases:
- Message arrives in the same cycle as the accepted tlast beat: treated as frame end, no DRAIN.
- GATE_ON_LAST = 0: DRAIN is never entered.
- Reset mid-pause: the gate opens one cycle after release, and in_frame is lost (cleared).

Test Plan:
1. Idle link, nfc_data = 0x0100 then 40 cycles later 0x0000 -> paused rises 2 cycles after the XOFF and falls 2 cycles after the XON; no m_axis beats while paused.
2. GATE_ON_LAST = 1, a 10-beat frame streaming continuously, XOFF at beat 3 -> beats 4-10 pass including tlast, then the gate closes; the next frame is held until XON.
3. nfc_data = 0x0005, QUANTUM = 8, idle -> paused is high for exactly 40 cycles, then reopens with no XON.
4. Timed 0x0003 then 0x0100 at cycle 10 of the pause -> stays paused indefinitely until 0x0000; then 0x0100 with XOFF_TIMEOUT = 100 and no XON -> xoff_timeout pulses once at cycle 100 and the gate reopens.
5. nfc_data = 0x8100 -> single-cycle nfc_err, paused unchanged, nfc_ready stays 1.
6. rst_n asserted for 3 cycles during PAUSE_XOFF mid-frame -> m_axis_tvalid = 0 and s_axis_tready = 0 during reset, gate open 1 cycle after release, next message decoded normally.

Source files
------------

// File: rtl/nfc_rx_ctrl.sv
// Far-end NFC consumer: decodes XOFF / XON / timed-pause messages and gates the
// user TX AXI-Stream path, closing the gate only at frame boundaries when enabled.
module nfc_rx_ctrl #(
  parameter int DATA_W       = 32,
  parameter int QUANTUM      = 8,
  parameter int GATE_ON_LAST = 1,
  parameter int XOFF_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              nfc_valid,
  input  logic [15:0]       nfc_data,
  output logic              nfc_ready,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              paused,
  output logic              nfc_err,
  output logic              xoff_timeout
);

  // state       | meaning
  // RUN         | gate open, no pause requested
  // DRAIN       | pause requested mid-frame, gate open until tlast is accepted
  // PAUSE_XOFF  | gate closed until XON (or watchdog expiry)
  // PAUSE_TIMED | gate closed until the pause counter reaches zero

  localparam int CNT_W = 8 + $clog2(QUANTUM);
  localparam int WD_W  = (XOFF_TIMEOUT > 0) ? $clog2(XOFF_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((XOFF_TIMEOUT > 0) ? XOFF_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {RUN, DRAIN, PAUSE_XOFF, PAUSE_TIMED} state_t;

  state_t            state_q, state_d;
  logic              gate_open, gate_open_d;
  logic              in_frame;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              pend_xoff_q, pend_xoff_d;
  logic [7:0]        pend_cnt_q, pend_cnt_d;

  logic              msg, illegal, is_xoff, is_xon, is_timed;
  logic              beat, frame_end;
  logic [CNT_W-1:0]  timed_load, pend_load;

  assign m_axis_tvalid = s_axis_tvalid & gate_open;
  assign s_axis_tready = m_axis_tready & gate_open;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = s_axis_tlast;
  assign paused        = ~gate_open;

  assign msg       = nfc_valid & nfc_ready;
  assign illegal   = |nfc_data[15:9];
  assign is_xoff   = msg & ~illegal & nfc_data[8];
  assign is_xon    = msg & ~illegal & ~nfc_data[8] & (nfc_data[7:0] == 8'd0);
  assign is_timed  = msg & ~illegal & ~nfc_data[8] & (nfc_data[7:0] != 8'd0);
  assign beat      = s_axis_tvalid & s_axis_tready;
  assign frame_end = beat & s_axis_tlast;

  assign timed_load = CNT_W'(int'(nfc_data[7:0]) * QUANTUM - 1);
  assign pend_load  = CNT_W'(int'(pend_cnt_q) * QUANTUM - 1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    pend_xoff_d  = pend_xoff_q;
    pend_cnt_d   = pend_cnt_q;
    nfc_err      = msg & illegal;
    xoff_timeout = 1'b0;

    if (is_xoff || is_timed) begin
      pend_xoff_d = is_xoff;
      pend_cnt_d  = nfc_data[7:0];
    end

    case (state_q)
      RUN: begin
        if (is_xoff || is_timed) begin
          if ((GATE_ON_LAST != 0) && in_frame && !frame_end) begin
            state_d = DRAIN;
          end else if (is_xoff) begin
            state_d = PAUSE_XOFF;
            wd_d    = '0;
          end else begin
            state_d = PAUSE_TIMED;
            cnt_d   = timed_load;
          end
        end
      end
      DRAIN: begin
        if (is_xon) begin
          state_d = RUN;
        end else if (frame_end) begin
          // a message arriving with the final beat overrides the pending one
          if (is_xoff || (!is_timed && pend_xoff_q)) begin
            state_d = PAUSE_XOFF;
            wd_d    = '0;
          end else begin
            state_d = PAUSE_TIMED;
            cnt_d   = is_timed ? timed_load : pend_load;
          end
        end
      end
      PAUSE_XOFF: begin
        if (is_xon) begin
          state_d = RUN;
        end else if (is_timed) begin
          state_d = PAUSE_TIMED;
          cnt_d   = timed_load;
        end else if (is_xoff) begin
          wd_d = '0;
        end else if ((XOFF_TIMEOUT != 0) && (wd_q == WD_LAST)) begin
          state_d      = RUN;
          xoff_timeout = 1'b1;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      PAUSE_TIMED: begin
        if (is_xon) begin
          state_d = RUN;
        end else if (is_xoff) begin
          state_d = PAUSE_XOFF;
          wd_d    = '0;
        end else if (is_timed) begin
          cnt_d = timed_load;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // leaving DRAIN closes the gate at once so the next frame cannot start
    gate_open_d = (state_q == RUN) ||
                  ((state_q == DRAIN) && ((state_d == DRAIN) || (state_d == RUN)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      gate_open   <= 1'b0;
      nfc_ready   <= 1'b0;
      in_frame    <= 1'b0;
      cnt_q       <= '0;
      wd_q        <= '0;
      pend_xoff_q <= 1'b0;
      pend_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gate_open   <= gate_open_d;
      nfc_ready   <= 1'b1;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      pend_xoff_q <= pend_xoff_d;
      pend_cnt_q  <= pend_cnt_d;
      if (beat) in_frame <= ~s_axis_tlast;
    end
  end

endmodule

// File: tb/tb_nfc_rx_ctrl.sv
// Scoreboard bench for nfc_rx_ctrl: directed NFC messages and frames push
// expected gate events and beats; a negedge monitor pops and compares them.
module tb_nfc_rx_ctrl;
  localparam int DATA_W  = 32;
  localparam int QUANTUM = 8;
  localparam int TMO     = 100;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_ERR  = 2;
  localparam int EV_TMO  = 3;

  typedef struct {int kind; int cyc;} ev_t;
  typedef struct {logic [DATA_W-1:0] data; logic last; int cyc;} beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nfc_valid = 1'b0;
  logic [15:0] nfc_data = 16'h0;
  logic nfc_ready;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic s_axis_tlast = 1'b0;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b1;
  logic [DATA_W-1:0] m_axis_tdata;
  logic m_axis_tlast;
  logic paused, nfc_err, xoff_timeout;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t   exp_ev_q[$];
  beat_t exp_beat_q[$];
  beat_t src_q[$];
  logic prev_paused = 1'b1;
  logic hs_s = 1'b0;

  nfc_rx_ctrl #(
    .DATA_W(DATA_W), .QUANTUM(QUANTUM), .GATE_ON_LAST(1), .XOFF_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .nfc_valid(nfc_valid), .nfc_data(nfc_data), .nfc_ready(nfc_ready),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .paused(paused), .nfc_err(nfc_err), .xoff_timeout(xoff_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // upstream source: presents the queue head, pops after a completed handshake
  always begin
    @(negedge clk);
    hs_s = s_axis_tvalid && s_axis_tready;
    @(posedge clk);
    #2;
    if (hs_s && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src_q[0].data;
      s_axis_tlast  = src_q[0].last;
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
    end
  end

  task automatic got_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_ev_q.size() == 0) begin
      errors++;
      $display("FAIL event unexpected kind=%0d at cyc=%0d", kind, cyc);
    end else begin
      e = exp_ev_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL event got kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    beat_t b;
    checks++;
    if (m_axis_tvalid && paused) begin
      errors++;
      $display("FAIL beat_while_paused m_axis_tvalid=1 paused=1 at cyc=%0d", cyc);
    end
    if (paused !== prev_paused) got_ev(paused ? EV_RISE : EV_FALL);
    prev_paused = paused;
    if (nfc_err) got_ev(EV_ERR);
    if (xoff_timeout) got_ev(EV_TMO);
    if (m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (exp_beat_q.size() == 0) begin
        errors++;
        $display("FAIL beat unexpected data=%h at cyc=%0d", m_axis_tdata, cyc);
      end else begin
        b = exp_beat_q.pop_front();
        if (m_axis_tdata !== b.data || m_axis_tlast !== b.last || cyc != b.cyc) begin
          errors++;
          $display("FAIL beat got data=%h last=%b cyc=%0d expected data=%h last=%b cyc=%0d",
                   m_axis_tdata, m_axis_tlast, cyc, b.data, b.last, b.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic send_msg(input logic [15:0] d);
    nfc_valid = 1'b1;
    nfc_data  = d;
    tick();
    nfc_valid = 1'b0;
    nfc_data  = 16'h0;
  endtask

  task automatic exp_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_ev_q.push_back(e);
  endtask

  task automatic push_beat(input logic [DATA_W-1:0] d, input logic l, input int c,
                           input bit expect_out);
    beat_t b;
    b.data = d;
    b.last = l;
    b.cyc  = c;
    src_q.push_back(b);
    if (expect_out) exp_beat_q.push_back(b);
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%b expected=%b at cyc=%0d", name, act, req, cyc);
    end
  endtask

  initial begin
    int t, x;
    repeat (3) tick();
    check1("reset_paused", paused, 1'b1);
    check1("reset_nfc_ready", nfc_ready, 1'b0);
    check1("reset_nfc_err", nfc_err, 1'b0);
    check1("reset_xoff_timeout", xoff_timeout, 1'b0);
    check1("reset_m_tvalid", m_axis_tvalid, 1'b0);
    rst_n = 1'b1;
    exp_ev(EV_FALL, cyc + 1);
    tick();
    check1("nfc_ready_after_release", nfc_ready, 1'b1);
    repeat (4) tick();

    // 1: XOFF on idle link, XON 40 cycles later
    t = cyc;
    exp_ev(EV_RISE, t + 2);
    send_msg(16'h0100);
    wait_until(t + 40);
    exp_ev(EV_FALL, t + 42);
    send_msg(16'h0000);
    wait_until(t + 50);

    // 2: 10-beat frame, XOFF at beat 3 drains to tlast; next frame held until XON
    t = cyc;
    x = t + 30;
    for (int k = 1; k <= 10; k++) push_beat(32'h200 + k, k == 10, t + k - 1, 1'b1);
    for (int k = 1; k <= 3; k++)  push_beat(32'h300 + k, k == 3, x + 2 + k - 1, 1'b1);
    exp_ev(EV_RISE, t + 10);
    wait_until(t + 2);
    send_msg(16'h0100);
    wait_until(x);
    exp_ev(EV_FALL, x + 2);
    send_msg(16'h0000);
    wait_until(x + 10);

    // 3: timed pause of 5 quanta, reopens without XON
    t = cyc;
    exp_ev(EV_RISE, t + 2);
    exp_ev(EV_FALL, t + 2 + 5 * QUANTUM);
    send_msg(16'h0005);
    wait_until(t + 50);

    // 4: timed pause overridden by XOFF, XON, then watchdog expiry
    t = cyc;
    exp_ev(EV_RISE, t + 2);
    send_msg(16'h0003);
    wait_until(t + 11);
    send_msg(16'h0100);
    wait_until(t + 60);
    exp_ev(EV_FALL, t + 62);
    send_msg(16'h0000);
    wait_until(t + 70);
    exp_ev(EV_RISE, t + 72);
    exp_ev(EV_TMO, t + 70 + TMO);
    exp_ev(EV_FALL, t + 72 + TMO);
    send_msg(16'h0100);
    wait_until(t + 80 + TMO);

    // 5: illegal messages pulse nfc_err and leave the gate alone
    t = cyc;
    check1("nfc_ready_before_illegal", nfc_ready, 1'b1);
    exp_ev(EV_ERR, t);
    send_msg(16'h8100);
    check1("nfc_ready_after_illegal", nfc_ready, 1'b1);
    check1("paused_after_illegal", paused, 1'b0);
    wait_until(t + 5);
    t = cyc;
    exp_ev(EV_RISE, t + 2);
    send_msg(16'h0100);
    wait_until(t + 5);
    exp_ev(EV_ERR, t + 5);
    send_msg(16'h0300);
    wait_until(t + 8);
    exp_ev(EV_ERR, t + 8);
    send_msg(16'h0200);
    wait_until(t + 12);
    exp_ev(EV_FALL, t + 14);
    send_msg(16'h0000);
    wait_until(t + 20);

    // 7: XOFF in the same cycle as the final tlast beat closes without draining
    t = cyc;
    push_beat(32'h701, 1'b0, t, 1'b1);
    push_beat(32'h702, 1'b1, t + 1, 1'b1);
    tick();
    exp_ev(EV_RISE, t + 3);
    send_msg(16'h0100);
    wait_until(t + 10);
    exp_ev(EV_FALL, t + 12);
    send_msg(16'h0000);
    wait_until(t + 16);

    // 8: timed pause requested mid-frame drains, then runs 2 quanta
    t = cyc;
    for (int k = 1; k <= 4; k++) push_beat(32'h800 + k, k == 4, t + k - 1, 1'b1);
    tick();
    exp_ev(EV_RISE, t + 4);
    exp_ev(EV_FALL, t + 21);
    send_msg(16'h0002);
    wait_until(t + 28);

    // 6: reset during PAUSE_XOFF mid-frame
    t = cyc;
    push_beat(32'h601, 1'b0, t, 1'b1);
    push_beat(32'h602, 1'b0, t + 1, 1'b1);
    push_beat(32'h603, 1'b0, 0, 1'b0);
    push_beat(32'h604, 1'b1, 0, 1'b0);
    exp_ev(EV_RISE, t + 2);
    send_msg(16'h0100);
    wait_until(t + 5);
    rst_n = 1'b0;
    tick();
    check1("rst_s_tvalid_held", s_axis_tvalid, 1'b1);
    check1("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check1("rst_s_tready", s_axis_tready, 1'b0);
    tick();
    check1("rst_m_tvalid_2", m_axis_tvalid, 1'b0);
    check1("rst_s_tready_2", s_axis_tready, 1'b0);
    check1("rst_paused", paused, 1'b1);
    tick();
    rst_n = 1'b1;
    src_q.delete();
    exp_ev(EV_FALL, t + 9);
    wait_until(t + 12);
    exp_ev(EV_RISE, t + 14);
    send_msg(16'h0100);
    wait_until(t + 20);
    exp_ev(EV_FALL, t + 22);
    send_msg(16'h0000);
    wait_until(t + 30);

    checks++;
    if (exp_ev_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=0 expected=%0d next kind=%0d cyc=%0d",
               exp_ev_q.size(), exp_ev_q[0].kind, exp_ev_q[0].cyc);
    end
    checks++;
    if (exp_beat_q.size() != 0) begin
      errors++;
      $display("FAIL missing_beats got=0 expected=%0d", exp_beat_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
